// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped branch predictor with branch target buffer.
//                Each entry holds {valid, tag, 2-bit saturating counter,
//                target}. A lookup issued by fetch returns a registered
//                prediction one cycle later. A resolved branch from execute
//                trains the indexed entry on the same edge. When the lookup
//                and the update hit the same index on one edge, the lookup
//                sees the updated entry (write-first bypass).
//
//  Parameters  : XLEN    - PC / target width
//                ENTRIES - table depth (power of two, >= 2)
//
//  Ports       : clk          - clock, rising edge active
//                rst_b        - asynchronous active-low reset
//                pred_req     - lookup request from fetch
//                pred_pc      - PC to look up
//                flush        - cancels the lookup on this edge
//                pred_valid   - registered prediction valid
//                pred_taken   - registered predicted direction
//                pred_target  - registered predicted next PC
//                upd_valid    - resolved-branch update strobe
//                upd_pc       - PC of the resolved branch
//                upd_taken    - resolved direction
//                upd_target   - resolved target
//
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            pred_req,
    input  logic [XLEN-1:0] pred_pc,
    input  logic            flush,
    output logic            pred_valid,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;

    localparam logic [1:0]      c_CTR_MAX   = 2'b11;
    localparam logic [1:0]      c_CTR_MIN   = 2'b00;
    localparam logic [1:0]      c_CTR_RESET = 2'b01;
    localparam logic [1:0]      c_CTR_ALLOC = 2'b10;
    localparam logic [XLEN-1:0] c_PC_STEP   = XLEN'(4);

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] r_valid;
    logic [TAGW-1:0]    r_tag    [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    logic [XLEN-1:0]    r_target [ENTRIES];

    // Prediction output registers
    logic               r_pred_valid;
    logic               r_pred_taken;
    logic [XLEN-1:0]    r_pred_target;

    // ------------------------------------------------------------------
    // Update path: compute the post-update contents of the indexed entry
    // ------------------------------------------------------------------
    logic [IDXW-1:0]    w_upd_idx;
    logic [TAGW-1:0]    w_upd_tag;
    logic               w_upd_hit;
    logic               w_upd_we;
    logic [1:0]         w_upd_ctr;
    logic [XLEN-1:0]    w_upd_tgt;

    assign w_upd_idx = upd_pc[IDXW+1:2];
    assign w_upd_tag = upd_pc[XLEN-1:IDXW+2];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    always_comb begin
        w_upd_we  = 1'b0;
        w_upd_ctr = r_ctr[w_upd_idx];
        w_upd_tgt = r_target[w_upd_idx];
        if (upd_valid) begin
            if (w_upd_hit) begin
                // Trained entry: saturating counter step, target follows
                // only taken outcomes so a not-taken branch keeps its BTB.
                w_upd_we = 1'b1;
                if (upd_taken) begin
                    if (r_ctr[w_upd_idx] != c_CTR_MAX) begin
                        w_upd_ctr = r_ctr[w_upd_idx] + 2'b01;
                    end
                    w_upd_tgt = upd_target;
                end else begin
                    if (r_ctr[w_upd_idx] != c_CTR_MIN) begin
                        w_upd_ctr = r_ctr[w_upd_idx] - 2'b01;
                    end
                end
            end else if (upd_taken) begin
                // Miss: only taken branches earn a slot (weakly taken).
                w_upd_we  = 1'b1;
                w_upd_ctr = c_CTR_ALLOC;
                w_upd_tgt = upd_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_ctr[i]    <= c_CTR_RESET;
                r_target[i] <= '0;
            end
        end else if (w_upd_we) begin
            r_valid[w_upd_idx]  <= 1'b1;
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_ctr[w_upd_idx]    <= w_upd_ctr;
            r_target[w_upd_idx] <= w_upd_tgt;
        end
    end

    // ------------------------------------------------------------------
    // Lookup path with write-first bypass from the update path
    // ------------------------------------------------------------------
    logic [IDXW-1:0]    w_lk_idx;
    logic [TAGW-1:0]    w_lk_tag;
    logic               w_lk_bypass;
    logic               w_lk_valid;
    logic [TAGW-1:0]    w_lk_stag;
    logic [1:0]         w_lk_ctr;
    logic [XLEN-1:0]    w_lk_stgt;
    logic               w_lk_hit;
    logic               w_lk_taken;
    logic [XLEN-1:0]    w_lk_target;

    assign w_lk_idx    = pred_pc[IDXW+1:2];
    assign w_lk_tag    = pred_pc[XLEN-1:IDXW+2];
    assign w_lk_bypass = w_upd_we && (w_upd_idx == w_lk_idx);

    // When the same entry is being written this edge, present its new value.
    assign w_lk_valid  = w_lk_bypass ? 1'b1       : r_valid[w_lk_idx];
    assign w_lk_stag   = w_lk_bypass ? w_upd_tag  : r_tag[w_lk_idx];
    assign w_lk_ctr    = w_lk_bypass ? w_upd_ctr  : r_ctr[w_lk_idx];
    assign w_lk_stgt   = w_lk_bypass ? w_upd_tgt  : r_target[w_lk_idx];

    assign w_lk_hit    = w_lk_valid && (w_lk_stag == w_lk_tag);
    assign w_lk_taken  = w_lk_hit && w_lk_ctr[1];
    assign w_lk_target = w_lk_taken ? w_lk_stgt : (pred_pc + c_PC_STEP);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_pred_valid  <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
        end else if (pred_req && !flush) begin
            r_pred_valid  <= 1'b1;
            r_pred_taken  <= w_lk_taken;
            r_pred_target <= w_lk_target;
        end else begin
            // No request or a flush: drop valid, hold the last prediction.
            r_pred_valid  <= 1'b0;
        end
    end

    assign pred_valid  = r_pred_valid;
    assign pred_taken  = r_pred_taken;
    assign pred_target = r_pred_target;

    // Byte-offset bits of the update PC never affect the table.
    logic w_unused_upd_lsb;
    assign w_unused_upd_lsb = ^upd_pc[1:0];

endmodule
`default_nettype wire
